// File: rtl/sub_share_pkg.sv
// sub_share_pkg: shared sizing and in-flight tag type for the subtractor-sharing arbiter
package sub_share_pkg;
  localparam int NREQ = 4;
  localparam int W = 16;
  localparam int LAT = 2;
  localparam int ID_W = $clog2(NREQ);
  typedef struct packed {
    logic valid;
    logic [ID_W-1:0] id;
    logic borrow;
  } tag_t;
endpackage

// File: rtl/sub_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick of the first eligible index at or after ptr
module rr_pick
  import sub_share_pkg::*;
(
  input  logic [NREQ-1:0] elig,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);
  logic [ID_W-1:0] c;
  // scan farthest-first so the candidate closest to ptr is the one left standing
  always_comb begin
    c = '0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      c = ID_W'((int'(ptr) + i) % NREQ);
      if (elig[c]) begin
        gnt = NREQ'(1) << c;
        idx = c;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sub_share_arbiter.sv
// sub_share_arbiter: round-robin sharing of one registered LAT-cycle subtractor among NREQ requesters
module sub_share_arbiter
  import sub_share_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_a0,
  input  logic [NREQ*W-1:0] req_a1,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      dp_a0,
  output logic [W-1:0]      dp_a1,
  input  logic [W-1:0]      dp_y,
  output logic              dp_rst_n,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_borrow,
  output logic [NREQ-1:0]   busy
);
  logic [ID_W-1:0] ptr, idx;
  logic any;
  tag_t pipe [LAT];
  tag_t tail;
  rr_pick u_pick (
    .elig(req & ~busy & {NREQ{en & dp_rst_n}}),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );
  assign dp_a0 = any ? req_a0[idx*W +: W] : '0;
  assign dp_a1 = any ? req_a1[idx*W +: W] : '0;
  assign tail = pipe[LAT-1];
  // the tag leaving the last stage lines up with dp_y for the op it describes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= '0;
      busy <= '0;
      dp_rst_n <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
      rsp_borrow <= 1'b0;
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      dp_rst_n <= 1'b1;
      pipe[0] <= tag_t'{valid: any, id: idx, borrow: dp_a0 < dp_a1};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      if (any) ptr <= (idx == ID_W'(NREQ - 1)) ? '0 : idx + 1'b1;
      busy <= (busy | gnt) & ~({{(NREQ-1){1'b0}}, tail.valid} << tail.id);
      rsp_valid <= tail.valid;
      if (tail.valid) begin
        rsp_id <= tail.id;
        rsp_data <= dp_y;
        rsp_borrow <= tail.borrow;
      end
    end
endmodule

// File: tb/tb_sub_share_arbiter.sv
// tb_sub_share_arbiter: directed stimulus, per-cycle reference model compare plus literal spot checks
module tb_sub_share_arbiter;
  import sub_share_pkg::*;
  logic clk, rst, en;
  logic [NREQ-1:0] req, gnt, busy;
  logic [NREQ*W-1:0] req_a0, req_a1;
  logic [W-1:0] dp_a0, dp_a1, dp_y, rsp_data, s1;
  logic dp_rst_n, rsp_valid, rsp_borrow;
  logic [ID_W-1:0] rsp_id;
  int n_pass = 0, n_chk = 0;

  sub_share_arbiter dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .req_a0(req_a0), .req_a1(req_a1),
    .gnt(gnt), .dp_a0(dp_a0), .dp_a1(dp_a1), .dp_y(dp_y), .dp_rst_n(dp_rst_n),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_borrow(rsp_borrow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // two-stage registered subtractor standing in for the shared datapath
  always @(posedge clk)
    if (!dp_rst_n) begin
      s1 <= '0;
      dp_y <= '0;
    end else begin
      s1 <= dp_a0 - dp_a1;
      dp_y <= s1;
    end

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  typedef struct {
    int id;
    logic [W-1:0] a0, a1;
    int age;
  } op_t;
  op_t q[$];
  int m_ptr, e_k, j;
  logic [NREQ-1:0] m_busy, e_gnt;
  logic m_rv, m_rb, m_dp;
  logic [ID_W-1:0] m_rid;
  logic [W-1:0] m_rd, e_a0, e_a1;

  // reference model: ops age in a queue and answer LAT edges after issue
  always @(negedge clk) begin
    #2;
    if (rst) begin
      m_ptr = 0; m_busy = '0; q.delete();
      m_rv = 0; m_rid = '0; m_rd = '0; m_rb = 0; m_dp = 0;
    end
    e_k = -1;
    if (!rst && en && m_dp)
      for (int o = 0; o < NREQ; o++) begin
        j = (m_ptr + o) % NREQ;
        if (e_k < 0 && req[j] && !m_busy[j]) e_k = j;
      end
    e_gnt = '0; e_a0 = '0; e_a1 = '0;
    if (e_k >= 0) begin
      e_gnt[e_k] = 1'b1;
      e_a0 = req_a0[e_k*W +: W];
      e_a1 = req_a1[e_k*W +: W];
    end
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("dp_a0", 32'(dp_a0), 32'(e_a0));
    check("dp_a1", 32'(dp_a1), 32'(e_a1));
    check("dp_rst_n", 32'(dp_rst_n), 32'(m_dp));
    check("busy", 32'(busy), 32'(m_busy));
    check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    check("rsp_id", 32'(rsp_id), 32'(m_rid));
    check("rsp_data", 32'(rsp_data), 32'(m_rd));
    check("rsp_borrow", 32'(rsp_borrow), 32'(m_rb));
    if (!rst) begin
      m_dp = 1;
      foreach (q[i]) q[i].age++;
      m_rv = 0;
      if (q.size() > 0 && q[0].age == LAT) begin
        m_rv = 1;
        m_rid = ID_W'(q[0].id);
        m_rd = q[0].a0 - q[0].a1;
        m_rb = q[0].a0 < q[0].a1;
        m_busy[q[0].id] = 1'b0;
        void'(q.pop_front());
      end
      if (e_k >= 0) begin
        q.push_back('{e_k, e_a0, e_a1, 0});
        m_busy[e_k] = 1'b1;
        m_ptr = (e_k + 1) % NREQ;
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1; en = 1; req = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a0[i*W +: W] = W'(16'h1000 * i + 16'h0111);
      req_a1[i*W +: W] = W'(16'h2000 - i);
    end
    step(2);
    rst = 0; req = 4'b1111;
    #3 check("rel_dp_rst_n", 32'(dp_rst_n), 0);
    check("rel_no_gnt", 32'(gnt), 0);
    step(1);
    for (int k = 0; k < 8; k++) begin
      #3 check("fair_gnt", 32'(gnt), 32'(1 << (k % 4)));
      if (k >= 3) check("fair_rsp_id", {31'(rsp_id), rsp_valid}, {31'((k - 3) % 4), 1'b1});
      step(1);
    end
    req = '0;
    step(4);
    req = 4'b1111;
    step(2);
    #1 rst = 1;
    #1 check("arst_valid", 32'(rsp_valid), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_dp_rst_n", 32'(dp_rst_n), 0);
    check("arst_data", {rsp_data, 13'(rsp_id), rsp_borrow, gnt[1:0]}, 0);
    req = '0;
    req_a0[2*W +: W] = 16'h1234;
    req_a1[2*W +: W] = 16'h0034;
    step(1);
    rst = 0; req = 4'b0100;
    #3 check("rel2_dp_rst_n", 32'(dp_rst_n), 0);
    check("rel2_no_gnt", 32'(gnt), 0);
    step(1);
    #3 check("single_gnt", 32'(gnt), 32'h4);
    check("single_a0", 32'(dp_a0), 32'h1234);
    check("single_a1", 32'(dp_a1), 32'h0034);
    step(1);
    req = '0;
    #3 check("single_busy", 32'(busy), 32'h4);
    step(2);
    #3 check("single_rsp", {rsp_valid, 3'(rsp_id), rsp_data, 3'(rsp_borrow)}, {1'b1, 3'd2, 16'h1200, 3'd0});
    check("single_busy_clr", 32'(busy), 0);
    step(1);
    req_a0[0*W +: W] = 16'h0000; req_a1[0*W +: W] = 16'h0001;
    req_a0[1*W +: W] = 16'h8000; req_a1[1*W +: W] = 16'h8000;
    req = 4'b0011;
    #3 check("wrap_gnt0", 32'(gnt), 32'h1);
    step(1);
    req = 4'b0010;
    #3 check("wrap_gnt1", 32'(gnt), 32'h2);
    step(1);
    req = '0;
    step(1);
    #3 check("wrap_rsp0", {rsp_valid, 3'(rsp_id), rsp_data, 3'(rsp_borrow)}, {1'b1, 3'd0, 16'hFFFF, 3'd1});
    step(1);
    #3 check("wrap_rsp1", {rsp_valid, 3'(rsp_id), rsp_data, 3'(rsp_borrow)}, {1'b1, 3'd1, 16'h0000, 3'd0});
    step(1);
    req_a0[1*W +: W] = 16'h0005; req_a1[1*W +: W] = 16'h0003;
    req = 4'b0010;
    for (int k = 0; k < 7; k++) begin
      #3 check("mask_gnt", 32'(gnt), (k % 3 == 0) ? 32'h2 : 32'h0);
      check("mask_busy", 32'(busy[1]), (k % 3 != 0) ? 32'h1 : 32'h0);
      step(1);
    end
    req = '0;
    step(4);
    req = 4'b0101;
    #3 check("en_gnt2", 32'(gnt), 32'h4);
    step(1);
    #3 check("en_gnt0", 32'(gnt), 32'h1);
    step(1);
    en = 0;
    for (int k = 0; k < 5; k++) begin
      #3 check("en_off_gnt", 32'(gnt), 0);
      if (k == 1) check("en_rsp2", {31'(rsp_id), rsp_valid}, {31'd2, 1'b1});
      if (k == 2) check("en_rsp0", {31'(rsp_id), rsp_valid}, {31'd0, 1'b1});
      if (k >= 3) check("en_busy", 32'(busy), 0);
      step(1);
    end
    en = 1;
    step(2);
    req = '0;
    step(5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
